// File: rtl/msrv32_instr_fetch_pkg.sv
// msrv32 global definitions shared by the fetch stage.
// Holds the NOP encoding, the default fetch depth, the instruction-buffer
// entry width and the fetch FSM state type.
package msrv32_instr_fetch_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Outstanding requests plus buffered instructions.
  localparam int FETCH_DEPTH = 2;

  // Instruction buffer entry: {instr[31:0], pc[31:0], misaligned}.
  localparam int IBUF_WIDTH = 65;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/msrv32_fetch_fifo.sv
// Small circular FIFO used for both the fetch PC queue and the instruction
// buffer.
// Ports:
//   clk_in, rst_in  - clock, asynchronous active-high reset
//   clr_in          - synchronous clear (wins over push/pop)
//   push_in, push_data_in - write port; a push while full is taken only
//                     together with a pop
//   pop_in          - removes the head entry when not empty
//   head_out        - current head entry
//   empty_out       - FIFO holds no entries
//   count_out       - number of entries held
module msrv32_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         clr_in,
  input  logic                         push_in,
  input  logic [WIDTH-1:0]             push_data_in,
  input  logic                         pop_in,
  output logic [WIDTH-1:0]             head_out,
  output logic                         empty_out,
  output logic [$clog2(DEPTH+1)-1:0]   count_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_out = (count_out == '0);
  assign full      = (count_out == CW'(DEPTH));
  assign head_out  = mem[rd_ptr];

  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign do_push = push_in && (!full || pop_in);
  assign do_pop  = pop_in && !empty_out;

  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_out <= '0;
    end else if (clr_in) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_out <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count_out <= count_out + CW'(1);
        2'b01:   count_out <= count_out - CW'(1);
        default: count_out <= count_out;
      endcase
    end
  end

endmodule

// File: rtl/msrv32_instr_fetch.sv
// Instruction fetch stage: takes fetch PCs, issues aligned ones to
// instruction memory, pairs in-order responses with their PCs and buffers the
// results for decode. Misaligned PCs bypass memory and yield a flagged NOP.
// flush_in discards everything in flight; responses to requests issued
// before the flush are swallowed in DRAIN.
// Handshakes: a transfer happens on a channel in every cycle where its
// valid and ready are both 1 (pc_valid_in/pc_ready_out,
// instr_valid_out/instr_ready_in, imem_req_out/imem_gnt_in); imem_rvalid_in
// has no back-pressure.
// Ports:
//   clk_in, rst_in                 - clock, asynchronous active-high reset
//   pc_in, pc_valid_in, pc_ready_out - fetch PC channel
//   imem_req_out, imem_addr_out, imem_gnt_in - memory request channel
//   imem_rvalid_in, imem_rdata_in  - in-order memory response
//   flush_in                       - redirect, discard in-flight fetches
//   instr_out, instr_pc_out, misaligned_out, instr_valid_out,
//   instr_ready_in                 - decode channel
//   state_out                      - current FSM state (debug)
module msrv32_instr_fetch
  import msrv32_instr_fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int          DEPTH        = FETCH_DEPTH
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [31:0]  pc_in,
  input  logic         pc_valid_in,
  output logic         pc_ready_out,
  output logic         imem_req_out,
  output logic [31:0]  imem_addr_out,
  input  logic         imem_gnt_in,
  input  logic         imem_rvalid_in,
  input  logic [31:0]  imem_rdata_in,
  input  logic         flush_in,
  output logic [31:0]  instr_out,
  output logic [31:0]  instr_pc_out,
  output logic         misaligned_out,
  output logic         instr_valid_out,
  input  logic         instr_ready_in,
  output fetch_state_e state_out
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e            state;
  logic [CW-1:0]           discard_cnt;
  logic [CW-1:0]           pcq_count;
  logic [CW-1:0]           ibuf_count;
  logic                    pcq_empty;
  logic                    ibuf_empty;
  logic [31:0]             pcq_head;
  logic [IBUF_WIDTH-1:0]   ibuf_head;
  logic [IBUF_WIDTH-1:0]   ibuf_push_data;
  logic [CW:0]             occupancy;
  logic [CW:0]             in_flight;
  logic                    pc_aligned;
  logic                    has_space;
  logic                    grant;
  logic                    resp_taken;
  logic                    resp_push;
  logic                    mis_push;
  logic                    ibuf_push;
  logic                    ibuf_pop;

  assign pc_aligned = (pc_in[1:0] == 2'b00);
  assign occupancy  = {1'b0, pcq_count} + {1'b0, ibuf_count};
  assign has_space  = (state == RUN) && (occupancy < (CW+1)'(DEPTH));

  // The request is not gated by flush_in: a grant in the flush cycle is
  // still counted as in flight and its response is discarded in DRAIN.
  assign imem_req_out  = pc_valid_in && pc_aligned && has_space;
  assign imem_addr_out = pc_in;
  assign grant         = imem_req_out && imem_gnt_in;

  // A misaligned PC waits until nothing is outstanding so its NOP cannot
  // overtake an older instruction (and never competes for the push port).
  assign pc_ready_out = has_space && !flush_in &&
                        (pc_aligned ? imem_gnt_in : pcq_empty);

  // A response only counts if something is actually outstanding; stray
  // responses (e.g. after a reset) are ignored.
  assign resp_taken = imem_rvalid_in &&
                      ((state == RUN) ? !pcq_empty : (discard_cnt != '0));
  assign resp_push  = resp_taken && (state == RUN) && !flush_in;
  assign mis_push   = pc_valid_in && pc_ready_out && !pc_aligned;
  assign ibuf_push  = resp_push || mis_push;
  assign ibuf_push_data = resp_push ? {imem_rdata_in, pcq_head, 1'b0}
                                    : {NOP_INSTR, pc_in, 1'b1};
  assign ibuf_pop   = instr_valid_out && instr_ready_in && !flush_in;

  // Requests still owed a response after this cycle's grant/response.
  assign in_flight = {1'b0, ((state == RUN) ? pcq_count : discard_cnt)}
                     + (CW+1)'(grant) - (CW+1)'(resp_taken);

  msrv32_fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_queue (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .clr_in       (flush_in),
    .push_in      (grant && !flush_in),
    .push_data_in (pc_in),
    .pop_in       (resp_push),
    .head_out     (pcq_head),
    .empty_out    (pcq_empty),
    .count_out    (pcq_count)
  );

  msrv32_fetch_fifo #(.WIDTH(IBUF_WIDTH), .DEPTH(DEPTH)) u_instr_buf (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .clr_in       (flush_in),
    .push_in      (ibuf_push),
    .push_data_in (ibuf_push_data),
    .pop_in       (ibuf_pop),
    .head_out     (ibuf_head),
    .empty_out    (ibuf_empty),
    .count_out    (ibuf_count)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= RUN;
      discard_cnt <= '0;
    end else if (flush_in) begin
      discard_cnt <= CW'(in_flight);
      state       <= (in_flight != '0) ? DRAIN : RUN;
    end else if ((state == DRAIN) && resp_taken) begin
      discard_cnt <= discard_cnt - CW'(1);
      if (discard_cnt == CW'(1)) state <= RUN;
    end
  end

  assign state_out       = state;
  assign instr_valid_out = (state == RUN) && !ibuf_empty;
  // Idle outputs show the reset values rather than a stale buffer entry.
  assign instr_out       = ibuf_empty ? NOP_INSTR    : ibuf_head[64:33];
  assign instr_pc_out    = ibuf_empty ? BOOT_ADDRESS : ibuf_head[32:1];
  assign misaligned_out  = ibuf_empty ? 1'b0         : ibuf_head[0];

endmodule

// File: tb/tb_msrv32_instr_fetch.sv
module tb_msrv32_instr_fetch;
  import msrv32_instr_fetch_pkg::*;

  localparam logic [31:0] BOOT = 32'h0000_0100;

  logic         clk_in;
  logic         rst_in;
  logic [31:0]  pc_in;
  logic         pc_valid_in;
  logic         pc_ready_out;
  logic         imem_req_out;
  logic [31:0]  imem_addr_out;
  logic         imem_gnt_in;
  logic         imem_rvalid_in;
  logic [31:0]  imem_rdata_in;
  logic         flush_in;
  logic [31:0]  instr_out;
  logic [31:0]  instr_pc_out;
  logic         misaligned_out;
  logic         instr_valid_out;
  logic         instr_ready_in;
  fetch_state_e state_out;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [31:0] exp_q[$];

  msrv32_instr_fetch #(.BOOT_ADDRESS(BOOT), .DEPTH(2)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .pc_in           (pc_in),
    .pc_valid_in     (pc_valid_in),
    .pc_ready_out    (pc_ready_out),
    .imem_req_out    (imem_req_out),
    .imem_addr_out   (imem_addr_out),
    .imem_gnt_in     (imem_gnt_in),
    .imem_rvalid_in  (imem_rvalid_in),
    .imem_rdata_in   (imem_rdata_in),
    .flush_in        (flush_in),
    .instr_out       (instr_out),
    .instr_pc_out    (instr_pc_out),
    .misaligned_out  (misaligned_out),
    .instr_valid_out (instr_valid_out),
    .instr_ready_in  (instr_ready_in),
    .state_out       (state_out)
  );

  // Clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_pc(input logic [31:0] pc, input logic valid, input logic gnt);
    pc_in       = pc;
    pc_valid_in = valid;
    imem_gnt_in = gnt;
    #1;
  endtask

  task automatic drive_resp(input logic valid, input logic [31:0] data);
    imem_rvalid_in = valid;
    imem_rdata_in  = data;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] exp_pc,
                            input logic [31:0] exp_instr, input logic exp_mis);
    #1;
    check({tag, "_valid"}, 32'(instr_valid_out), 32'd1);
    check({tag, "_instr"}, instr_out, exp_instr);
    check({tag, "_pc"}, instr_pc_out, exp_pc);
    check({tag, "_mis"}, 32'(misaligned_out), 32'(exp_mis));
    instr_ready_in = 1'b1;
    step();
    instr_ready_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1;
    pc_in = '0; pc_valid_in = 1'b0; imem_gnt_in = 1'b0;
    imem_rvalid_in = 1'b0; imem_rdata_in = '0;
    flush_in = 1'b0; instr_ready_in = 1'b0;
    step();
    step();
    check("rst_valid", 32'(instr_valid_out), 32'd0);
    check("rst_instr", instr_out, NOP_INSTR);
    check("rst_pc", instr_pc_out, BOOT);
    check("rst_mis", 32'(misaligned_out), 32'd0);
    check("rst_state", 32'(state_out), 32'(RUN));
    rst_in = 1'b0;
    step();

    // Basic fetch: grant, response one cycle later, visible the next cycle
    drive_pc(32'h0, 1'b1, 1'b1);
    check("a_req", 32'(imem_req_out), 32'd1);
    check("a_addr", imem_addr_out, 32'h0);
    check("a_ready", 32'(pc_ready_out), 32'd1);
    step();
    drive_pc(32'h0, 1'b0, 1'b0);
    drive_resp(1'b1, 32'h0050_0093);
    check("a_not_yet", 32'(instr_valid_out), 32'd0);
    step();
    drive_resp(1'b0, 32'h0);
    pop_expect("a", 32'h0, 32'h0050_0093, 1'b0);
    #1 check("a_empty", 32'(instr_valid_out), 32'd0);

    // Back-to-back PCs against a stalled decode: only two fit
    drive_pc(32'h0, 1'b1, 1'b1);
    check("b_ready0", 32'(pc_ready_out), 32'd1);
    step();
    drive_pc(32'h4, 1'b1, 1'b1);
    check("b_ready4", 32'(pc_ready_out), 32'd1);
    step();
    drive_pc(32'h8, 1'b1, 1'b1);
    check("b_ready8", 32'(pc_ready_out), 32'd0);
    check("b_req8", 32'(imem_req_out), 32'd0);
    drive_pc(32'h8, 1'b0, 1'b0);
    drive_resp(1'b1, 32'h0000_0a00);
    step();
    drive_resp(1'b1, 32'h0000_0a04);
    step();
    drive_resp(1'b0, 32'h0);
    drive_pc(32'h8, 1'b1, 1'b1);
    check("b_full", 32'(pc_ready_out), 32'd0);
    pop_expect("b0", 32'h0, 32'h0000_0a00, 1'b0);
    check("b_after_pop", 32'(pc_ready_out), 32'd1);
    step();
    drive_pc(32'h8, 1'b0, 1'b0);
    drive_resp(1'b1, 32'h0000_0a08);
    step();
    drive_resp(1'b0, 32'h0);
    pop_expect("b4", 32'h4, 32'h0000_0a04, 1'b0);
    pop_expect("b8", 32'h8, 32'h0000_0a08, 1'b0);

    // Misaligned PC yields a flagged NOP without a memory request
    drive_pc(32'h6, 1'b1, 1'b0);
    check("c_req", 32'(imem_req_out), 32'd0);
    check("c_ready", 32'(pc_ready_out), 32'd1);
    step();
    drive_pc(32'h6, 1'b0, 1'b0);
    pop_expect("c", 32'h6, NOP_INSTR, 1'b1);

    // Flush with two outstanding requests: both responses dropped
    drive_pc(32'h20, 1'b1, 1'b1);
    step();
    drive_pc(32'h24, 1'b1, 1'b1);
    step();
    drive_pc(32'h24, 1'b0, 1'b0);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    check("d_drain", 32'(state_out), 32'(DRAIN));
    check("d_valid0", 32'(instr_valid_out), 32'd0);
    drive_resp(1'b1, 32'h0bad_0020);
    step();
    check("d_drain1", 32'(state_out), 32'(DRAIN));
    check("d_valid1", 32'(instr_valid_out), 32'd0);
    drive_resp(1'b1, 32'h0bad_0024);
    step();
    drive_resp(1'b0, 32'h0);
    check("d_run", 32'(state_out), 32'(RUN));
    check("d_valid2", 32'(instr_valid_out), 32'd0);
    drive_pc(32'h30, 1'b1, 1'b1);
    step();
    drive_pc(32'h30, 1'b0, 1'b0);
    drive_resp(1'b1, 32'h0000_0b30);
    step();
    drive_resp(1'b0, 32'h0);
    pop_expect("d30", 32'h30, 32'h0000_0b30, 1'b0);

    // Simultaneous response and pop, order kept across pointer wrap
    drive_pc(32'h10, 1'b1, 1'b1);
    check("e_ready10", 32'(pc_ready_out), 32'd1);
    exp_q.push_back(32'h10);
    step();
    drive_resp(1'b1, 32'h0000_0a10);
    drive_pc(32'h14, 1'b1, 1'b1);
    check("e_ready14", 32'(pc_ready_out), 32'd1);
    exp_q.push_back(32'h14);
    step();
    drive_resp(1'b1, 32'h0000_0a14);
    drive_pc(32'h18, 1'b1, 1'b1);
    check("e_full", 32'(pc_ready_out), 32'd0);
    check("e_head10", instr_pc_out, exp_q.pop_front());
    check("e_instr10", instr_out, 32'h0000_0a10);
    instr_ready_in = 1'b1;
    step();
    instr_ready_in = 1'b0;
    drive_resp(1'b0, 32'h0);
    drive_pc(32'h18, 1'b1, 1'b1);
    check("e_ready18", 32'(pc_ready_out), 32'd1);
    exp_q.push_back(32'h18);
    step();
    drive_pc(32'h18, 1'b0, 1'b0);
    drive_resp(1'b1, 32'h0000_0a18);
    instr_ready_in = 1'b1;
    #1;
    check("e_head14", instr_pc_out, exp_q.pop_front());
    check("e_instr14", instr_out, 32'h0000_0a14);
    step();
    instr_ready_in = 1'b0;
    drive_resp(1'b0, 32'h0);
    pop_expect("e18", exp_q.pop_front(), 32'h0000_0a18, 1'b0);

    // Asynchronous reset with one outstanding and one buffered
    drive_pc(32'h40, 1'b1, 1'b1);
    step();
    drive_resp(1'b1, 32'h0000_0c40);
    drive_pc(32'h44, 1'b1, 1'b1);
    step();
    drive_resp(1'b0, 32'h0);
    drive_pc(32'h44, 1'b0, 1'b0);
    check("f_pre_valid", 32'(instr_valid_out), 32'd1);
    #1 rst_in = 1'b1;
    #1;
    check("f_valid", 32'(instr_valid_out), 32'd0);
    check("f_instr", instr_out, NOP_INSTR);
    check("f_pc", instr_pc_out, BOOT);
    check("f_mis", 32'(misaligned_out), 32'd0);
    step();
    rst_in = 1'b0;
    drive_resp(1'b1, 32'h0000_dead);
    step();
    drive_resp(1'b0, 32'h0);
    check("f_late_valid", 32'(instr_valid_out), 32'd0);
    drive_pc(32'h0, 1'b0, 1'b1);
    check("f_ready", 32'(pc_ready_out), 32'd1);
    drive_pc(32'h0, 1'b0, 1'b0);
    step();
    check("f_still_empty", 32'(instr_valid_out), 32'd0);

    // Final report
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
